// File: rtl/axi4lite_arb2m.sv
// axi4lite_arb2m: transaction-level arbiter/sequencer for a two-master AXI4-lite interconnect.
// It grants one whole read or write transaction at a time to m0 (JTAG debug) or m1 (core data port).
// It latches the target slave index, addr[31:28], so the interconnect muxes can route the transaction.
// Unmapped accesses are terminated locally with DECERR.
// A slave that does not respond within TIMEOUT cycles is aborted with SLVERR.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mX_awvalid/arvalid/wvalid        master request qualifiers
//   mX_awaddr/araddr                 master addresses (only [31:28] is decoded)
//   mX_bready/rready                 master response ready
//   bus_bvalid/bready/rvalid/rready  muxed slave-side response handshake
//   gnt, gnt_wr, slv_sel             latched grant, direction and slave index
//   slv_abort                        one-cycle pulse on timeout
//   err_aready, err_bvalid, err_rvalid, err_resp  arbiter-generated error path
module axi4lite_arb2m #(
    parameter int unsigned PRIO_MODE = 0,
    parameter logic [15:0] SLV_MASK  = 16'h0007,
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_awvalid,
    input  logic        m0_arvalid,
    input  logic        m0_wvalid,
    input  logic [31:0] m0_awaddr,
    input  logic [31:0] m0_araddr,
    input  logic        m0_bready,
    input  logic        m0_rready,
    input  logic        m1_awvalid,
    input  logic        m1_arvalid,
    input  logic        m1_wvalid,
    input  logic [31:0] m1_awaddr,
    input  logic [31:0] m1_araddr,
    input  logic        m1_bready,
    input  logic        m1_rready,
    input  logic        bus_bvalid,
    input  logic        bus_bready,
    input  logic        bus_rvalid,
    input  logic        bus_rready,
    output logic [1:0]  gnt,
    output logic        gnt_wr,
    output logic [3:0]  slv_sel,
    output logic        slv_abort,
    output logic        err_aready,
    output logic        err_bvalid,
    output logic        err_rvalid,
    output logic [1:0]  err_resp
);

    typedef enum logic [1:0] {IDLE, BUSY, ERR_ACC, ERR_RSP} state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             gnt_wr_q, gnt_wr_d;
    logic [3:0]       slv_sel_q, slv_sel_d;
    logic             last_gnt_q, last_gnt_d;   // 0 = m0, 1 = m1
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             slv_abort_q, slv_abort_d;
    logic             err_aready_q, err_aready_d;
    logic             err_bvalid_q, err_bvalid_d;
    logic             err_rvalid_q, err_rvalid_d;
    logic [1:0]       err_resp_q, err_resp_d;

    logic        req0, req1, win_m1, win_wr;
    logic [31:0] win_addr;
    logic [3:0]  win_slv;
    logic        complete, gnt_ready, gnt_wvalid;
    logic        unused_addr_bits;

    // Arbitration: m1 wins if alone, or in round-robin when m0 had the last grant.
    assign req0     = m0_awvalid | m0_arvalid;
    assign req1     = m1_awvalid | m1_arvalid;
    assign win_m1   = req1 & (~req0 | ((PRIO_MODE == 0) & ~last_gnt_q));
    assign win_wr   = win_m1 ? m1_awvalid : m0_awvalid;
    assign win_addr = win_m1 ? (win_wr ? m1_awaddr : m1_araddr)
                             : (win_wr ? m0_awaddr : m0_araddr);
    assign win_slv  = win_addr[31:28];

    assign complete   = gnt_wr_q ? (bus_bvalid & bus_bready) : (bus_rvalid & bus_rready);
    assign gnt_ready  = gnt_q[1] ? (gnt_wr_q ? m1_bready : m1_rready)
                                 : (gnt_wr_q ? m0_bready : m0_rready);
    assign gnt_wvalid = gnt_q[1] ? m1_wvalid : m0_wvalid;

    assign unused_addr_bits = ^{m0_awaddr[27:0], m0_araddr[27:0], m1_awaddr[27:0], m1_araddr[27:0]};

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gnt_wr_d     = gnt_wr_q;
        slv_sel_d    = slv_sel_q;
        last_gnt_d   = last_gnt_q;
        cnt_d        = cnt_q;
        slv_abort_d  = 1'b0;
        err_aready_d = err_aready_q;
        err_bvalid_d = err_bvalid_q;
        err_rvalid_d = err_rvalid_q;
        err_resp_d   = err_resp_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    gnt_d      = win_m1 ? 2'b10 : 2'b01;
                    gnt_wr_d   = win_wr;
                    slv_sel_d  = win_slv;
                    last_gnt_d = win_m1;
                    cnt_d      = '0;
                    if (SLV_MASK[win_slv]) begin
                        state_d = BUSY;
                    end else begin
                        state_d      = ERR_ACC;
                        err_aready_d = 1'b1;
                        err_resp_d   = 2'b11;
                    end
                end
            end
            BUSY: begin
                // Completion takes precedence over a coincident timeout.
                if (complete) begin
                    state_d   = IDLE;
                    gnt_d     = 2'b00;
                    gnt_wr_d  = 1'b0;
                    slv_sel_d = 4'd0;
                    cnt_d     = '0;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    state_d      = ERR_RSP;
                    slv_abort_d  = 1'b1;
                    err_resp_d   = 2'b10;
                    err_bvalid_d = gnt_wr_q;
                    err_rvalid_d = ~gnt_wr_q;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR_ACC: begin
                // A write is accepted only together with its data beat.
                if (~gnt_wr_q | gnt_wvalid) begin
                    state_d      = ERR_RSP;
                    err_aready_d = 1'b0;
                    err_bvalid_d = gnt_wr_q;
                    err_rvalid_d = ~gnt_wr_q;
                end
            end
            ERR_RSP: begin
                if (gnt_ready) begin
                    state_d      = IDLE;
                    gnt_d        = 2'b00;
                    gnt_wr_d     = 1'b0;
                    slv_sel_d    = 4'd0;
                    err_bvalid_d = 1'b0;
                    err_rvalid_d = 1'b0;
                    err_resp_d   = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gnt_q        <= 2'b00;
            gnt_wr_q     <= 1'b0;
            slv_sel_q    <= 4'd0;
            last_gnt_q   <= 1'b1;
            cnt_q        <= '0;
            slv_abort_q  <= 1'b0;
            err_aready_q <= 1'b0;
            err_bvalid_q <= 1'b0;
            err_rvalid_q <= 1'b0;
            err_resp_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gnt_wr_q     <= gnt_wr_d;
            slv_sel_q    <= slv_sel_d;
            last_gnt_q   <= last_gnt_d;
            cnt_q        <= cnt_d;
            slv_abort_q  <= slv_abort_d;
            err_aready_q <= err_aready_d;
            err_bvalid_q <= err_bvalid_d;
            err_rvalid_q <= err_rvalid_d;
            err_resp_q   <= err_resp_d;
        end
    end

    assign gnt        = gnt_q;
    assign gnt_wr     = gnt_wr_q;
    assign slv_sel    = slv_sel_q;
    assign slv_abort  = slv_abort_q;
    assign err_aready = err_aready_q;
    assign err_bvalid = err_bvalid_q;
    assign err_rvalid = err_rvalid_q;
    assign err_resp   = err_resp_q;

endmodule

// File: tb/tb_axi4lite_arb2m.sv
// Directed bench for axi4lite_arb2m.
// Instance dut runs round-robin arbitration with a 16-cycle timeout.
// Instance dut_p runs fixed priority on the same stimulus.
module tb_axi4lite_arb2m;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_awvalid, m0_arvalid, m0_wvalid, m0_bready, m0_rready;
    logic [31:0] m0_awaddr, m0_araddr;
    logic        m1_awvalid, m1_arvalid, m1_wvalid, m1_bready, m1_rready;
    logic [31:0] m1_awaddr, m1_araddr;
    logic        bus_bvalid, bus_bready, bus_rvalid, bus_rready;

    logic [1:0]  gnt, err_resp, p_gnt, p_err_resp;
    logic        gnt_wr, slv_abort, err_aready, err_bvalid, err_rvalid;
    logic        p_gnt_wr, p_slv_abort, p_err_aready, p_err_bvalid, p_err_rvalid;
    logic [3:0]  slv_sel, p_slv_sel;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    axi4lite_arb2m #(.PRIO_MODE(0), .SLV_MASK(16'h0007), .TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .m0_awvalid(m0_awvalid), .m0_arvalid(m0_arvalid), .m0_wvalid(m0_wvalid),
        .m0_awaddr(m0_awaddr), .m0_araddr(m0_araddr), .m0_bready(m0_bready), .m0_rready(m0_rready),
        .m1_awvalid(m1_awvalid), .m1_arvalid(m1_arvalid), .m1_wvalid(m1_wvalid),
        .m1_awaddr(m1_awaddr), .m1_araddr(m1_araddr), .m1_bready(m1_bready), .m1_rready(m1_rready),
        .bus_bvalid(bus_bvalid), .bus_bready(bus_bready), .bus_rvalid(bus_rvalid), .bus_rready(bus_rready),
        .gnt(gnt), .gnt_wr(gnt_wr), .slv_sel(slv_sel), .slv_abort(slv_abort),
        .err_aready(err_aready), .err_bvalid(err_bvalid), .err_rvalid(err_rvalid), .err_resp(err_resp)
    );

    axi4lite_arb2m #(.PRIO_MODE(1), .SLV_MASK(16'h0007), .TIMEOUT(16), .CNT_W(5)) dut_p (
        .clk(clk), .rst(rst),
        .m0_awvalid(m0_awvalid), .m0_arvalid(m0_arvalid), .m0_wvalid(m0_wvalid),
        .m0_awaddr(m0_awaddr), .m0_araddr(m0_araddr), .m0_bready(m0_bready), .m0_rready(m0_rready),
        .m1_awvalid(m1_awvalid), .m1_arvalid(m1_arvalid), .m1_wvalid(m1_wvalid),
        .m1_awaddr(m1_awaddr), .m1_araddr(m1_araddr), .m1_bready(m1_bready), .m1_rready(m1_rready),
        .bus_bvalid(bus_bvalid), .bus_bready(bus_bready), .bus_rvalid(bus_rvalid), .bus_rready(bus_rready),
        .gnt(p_gnt), .gnt_wr(p_gnt_wr), .slv_sel(p_slv_sel), .slv_abort(p_slv_abort),
        .err_aready(p_err_aready), .err_bvalid(p_err_bvalid), .err_rvalid(p_err_rvalid), .err_resp(p_err_resp)
    );

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_awvalid = 0; m0_arvalid = 0; m0_wvalid = 0; m0_bready = 0; m0_rready = 0;
        m0_awaddr = '0; m0_araddr = '0;
        m1_awvalid = 0; m1_arvalid = 0; m1_wvalid = 0; m1_bready = 0; m1_rready = 0;
        m1_awaddr = '0; m1_araddr = '0;
        bus_bvalid = 0; bus_bready = 0; bus_rvalid = 0; bus_rready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        tests_run++;
        if ({gnt, gnt_wr, slv_sel, slv_abort, err_aready, err_bvalid, err_rvalid, err_resp} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got gnt=%b wr=%b sel=%0d abort=%b ardy=%b bv=%b rv=%b resp=%b, want all 0",
                     gnt, gnt_wr, slv_sel, slv_abort, err_aready, err_bvalid, err_rvalid, err_resp);
        end
        cyc();
        tests_run++;
        if (gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_idle: gnt=%b want 00", gnt);
        end
    endtask

    task automatic test_read_m1();
        m1_arvalid = 1; m1_araddr = 32'h1000_0004;
        cyc();
        m1_arvalid = 0;
        tests_run++;
        if ({gnt, gnt_wr, slv_sel} !== {2'b10, 1'b0, 4'd1}) begin
            tests_failed++;
            $display("FAIL read_grant: gnt=%b wr=%b sel=%0d want 10/0/1", gnt, gnt_wr, slv_sel);
        end
        cyc();
        tests_run++;
        if ({gnt, gnt_wr, slv_sel} !== {2'b10, 1'b0, 4'd1}) begin
            tests_failed++;
            $display("FAIL read_hold: gnt=%b wr=%b sel=%0d want 10/0/1", gnt, gnt_wr, slv_sel);
        end
        bus_rvalid = 1; bus_rready = 1;
        cyc();
        bus_rvalid = 0; bus_rready = 0;
        tests_run++;
        if (gnt !== 2'b00 || err_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_release: gnt=%b rv=%b want 00/0", gnt, err_rvalid);
        end
    endtask

    task automatic test_arbitration();
        logic [1:0] exp_rr [3];
        logic [3:0] exp_sel [3];
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01;
        exp_sel[0] = 4'd0; exp_sel[1] = 4'd2; exp_sel[2] = 4'd0;
        idle_inputs();
        rst = 1; cyc(); rst = 0;
        m0_awvalid = 1; m0_awaddr = 32'h0000_0010;
        m1_awvalid = 1; m1_awaddr = 32'h2000_0000;
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests_run++;
            if (gnt !== exp_rr[i] || gnt_wr !== 1'b1 || slv_sel !== exp_sel[i]) begin
                tests_failed++;
                $display("FAIL rr_round%0d: gnt=%b wr=%b sel=%0d want %b/1/%0d",
                         i, gnt, gnt_wr, slv_sel, exp_rr[i], exp_sel[i]);
            end
            tests_run++;
            if (p_gnt !== 2'b01 || p_slv_sel !== 4'd0) begin
                tests_failed++;
                $display("FAIL prio_round%0d: gnt=%b sel=%0d want 01/0", i, p_gnt, p_slv_sel);
            end
            bus_bvalid = 1; bus_bready = 1;
            cyc();
            bus_bvalid = 0; bus_bready = 0;
            tests_run++;
            if (gnt !== 2'b00 || p_gnt !== 2'b00) begin
                tests_failed++;
                $display("FAIL arb_gap%0d: gnt=%b p_gnt=%b want 00/00", i, gnt, p_gnt);
            end
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_unmapped_write();
        m1_awvalid = 1; m1_awaddr = 32'h5000_0000;
        cyc();
        tests_run++;
        if ({gnt, gnt_wr, slv_sel, err_aready, err_resp} !== {2'b10, 1'b1, 4'd5, 1'b1, 2'b11}) begin
            tests_failed++;
            $display("FAIL decerr_accept: gnt=%b wr=%b sel=%0d ardy=%b resp=%b want 10/1/5/1/11",
                     gnt, gnt_wr, slv_sel, err_aready, err_resp);
        end
        cyc();
        cyc();
        tests_run++;
        if (err_aready !== 1'b1 || err_bvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL decerr_wait_w: ardy=%b bv=%b want 1/0", err_aready, err_bvalid);
        end
        m1_wvalid = 1;
        cyc();
        m1_awvalid = 0; m1_wvalid = 0;
        tests_run++;
        if ({err_aready, err_bvalid, err_rvalid, err_resp} !== {1'b0, 1'b1, 1'b0, 2'b11}) begin
            tests_failed++;
            $display("FAIL decerr_resp: ardy=%b bv=%b rv=%b resp=%b want 0/1/0/11",
                     err_aready, err_bvalid, err_rvalid, err_resp);
        end
        cyc();
        cyc();
        tests_run++;
        if (err_bvalid !== 1'b1 || err_resp !== 2'b11 || gnt !== 2'b10) begin
            tests_failed++;
            $display("FAIL decerr_hold: bv=%b resp=%b gnt=%b want 1/11/10", err_bvalid, err_resp, gnt);
        end
        m1_bready = 1;
        cyc();
        m1_bready = 0;
        tests_run++;
        if (err_bvalid !== 1'b0 || gnt !== 2'b00) begin
            tests_failed++;
            $display("FAIL decerr_release: bv=%b gnt=%b want 0/00", err_bvalid, gnt);
        end
    endtask

    task automatic test_timeout();
        int early_abort;
        early_abort = 0;
        m1_arvalid = 1; m1_araddr = 32'h2000_0000;
        cyc();
        m1_arvalid = 0;
        for (int i = 1; i < 16; i++) begin
            cyc();
            if (slv_abort !== 1'b0 || err_rvalid !== 1'b0) early_abort++;
        end
        tests_run++;
        if (early_abort != 0) begin
            tests_failed++;
            $display("FAIL timeout_early: abort seen in %0d early cycles, want 0", early_abort);
        end
        cyc();
        tests_run++;
        if ({slv_abort, err_rvalid, err_bvalid, err_resp, gnt} !== {1'b1, 1'b1, 1'b0, 2'b10, 2'b10}) begin
            tests_failed++;
            $display("FAIL timeout_abort: abort=%b rv=%b bv=%b resp=%b gnt=%b want 1/1/0/10/10",
                     slv_abort, err_rvalid, err_bvalid, err_resp, gnt);
        end
        cyc();
        tests_run++;
        if (slv_abort !== 1'b0 || err_rvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_pulse: abort=%b rv=%b want 0/1", slv_abort, err_rvalid);
        end
        m1_rready = 1;
        cyc();
        m1_rready = 0;
        tests_run++;
        if (err_rvalid !== 1'b0 || gnt !== 2'b00 || err_resp !== 2'b00) begin
            tests_failed++;
            $display("FAIL timeout_release: rv=%b gnt=%b resp=%b want 0/00/00", err_rvalid, gnt, err_resp);
        end
    endtask

    task automatic test_timeout_race();
        m0_arvalid = 1; m0_araddr = 32'h0000_0000;
        cyc();
        m0_arvalid = 0;
        for (int i = 1; i < 16; i++) cyc();
        bus_rvalid = 1; bus_rready = 1;
        cyc();
        bus_rvalid = 0; bus_rready = 0;
        tests_run++;
        if ({slv_abort, err_rvalid, gnt} !== {1'b0, 1'b0, 2'b00}) begin
            tests_failed++;
            $display("FAIL race_completion: abort=%b rv=%b gnt=%b want 0/0/00", slv_abort, err_rvalid, gnt);
        end
    endtask

    task automatic test_reset_busy();
        m0_arvalid = 1; m0_araddr = 32'h1000_0000;
        cyc();
        m0_arvalid = 0;
        tests_run++;
        if (gnt !== 2'b01) begin
            tests_failed++;
            $display("FAIL rstbusy_grant: gnt=%b want 01", gnt);
        end
        cyc();
        rst = 1;
        cyc();
        rst = 0;
        tests_run++;
        if ({gnt, slv_abort, err_aready, err_bvalid, err_rvalid, err_resp} !== 8'd0) begin
            tests_failed++;
            $display("FAIL rstbusy_clear: gnt=%b abort=%b ardy=%b bv=%b rv=%b resp=%b want all 0",
                     gnt, slv_abort, err_aready, err_bvalid, err_rvalid, err_resp);
        end
        m0_awvalid = 1; m0_awaddr = 32'h0000_0000;
        m1_awvalid = 1; m1_awaddr = 32'h1000_0000;
        cyc();
        m0_awvalid = 0; m1_awvalid = 0;
        tests_run++;
        if (gnt !== 2'b01 || slv_sel !== 4'd0) begin
            tests_failed++;
            $display("FAIL rstbusy_rr: gnt=%b sel=%0d want 01/0", gnt, slv_sel);
        end
        bus_bvalid = 1; bus_bready = 1;
        cyc();
        bus_bvalid = 0; bus_bready = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_read_m1();
        test_arbitration();
        test_unmapped_write();
        test_timeout();
        test_timeout_race();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
